fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
- Round-robin, packet-locked arbiter that shares the single write port of the async FIFO between NREQ requesters.
- Sits entirely in the FIFO write clock domain, in front of the FIFO write-pointer/memory logic.
- Drives winc/wdata and obeys wfull.
- Once granted, a requester keeps the port until its last beat is written, so packets are never interleaved in the FIFO.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DSIZE, 8, FIFO data width in bits.
- IDW, $clog2(NREQ), localparam, width of the grant index.

Ports:
- wclk  in  1  FIFO write clock.
- wrst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*DSIZE  requester i data in bits [i*DSIZE +: DSIZE].
- req_last  in  NREQ  marks final beat of the packet.
- req_ready  out  NREQ  per-requester beat accepted this cycle.
- wfull  in  1  FIFO full flag.
- winc  out  1  FIFO write enable.
- wdata  out  DSIZE  FIFO write data.
- gnt_id  out  IDW  index of current owner.
- busy  out  1  high while in GRANT.

Behaviour:
- Clock and reset: one clock (wclk); reset wrst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, busy=0, gnt_id=0, last_id=NREQ-1, so requester 0 has first priority.
  - req_ready=0, winc=0.
  - wdata is combinational from the owner mux and is don't-care while winc=0.
- FSM IDLE:
  - If any req_valid is high, pick the first valid index searching from last_id+1 upward with wrap-around.
  - Register the pick into gnt_id, set last_id=pick, go to GRANT.
  - Arbitration takes 1 cycle; no beat is accepted in IDLE.
- FSM GRANT:
  - accept = req_valid[gnt_id] & !wfull.
  - winc = accept; req_ready[gnt_id] = !wfull; all other req_ready bits = 0.
  - wdata = req_data slice selected by gnt_id.
  - When accept & req_last[gnt_id], return to IDLE. This gives 1 bubble cycle between packets.
  - Single-beat packets (valid & last on the first beat) are legal.
- Requester rules:
  - Once valid is high, data/last must hold until ready.
  - If the owner drops valid mid-packet, the arbiter stays in GRANT and waits; the grant is never stolen.
- wfull:
  - While wfull=1, winc is never asserted and all req_ready bits are 0. State and gnt_id hold.
  - wfull rising in the same cycle as a valid beat means the beat is not accepted.
- Fairness: after requester k's packet, k has lowest priority in the next arbitration.
- Reset mid-packet: returns immediately to the reset values. The partial packet already in the FIFO is not the arbiter's concern.
- Combinational paths: winc/req_ready depend on wfull and req_valid; no registered skid.

Optional Feature:
- Macro: FIFO_WR_ARB_STALL_CNT_EN.
- When defined:
  - Add output stall_cnt (16 bits), reset to 0.
  - Increments each cycle with state==GRANT & req_valid[gnt_id] & wfull.
  - Saturates at 16'hFFFF.
  - Clears on a 1-cycle input stall_clr; clear has priority over increment.
- When undefined: the port and the counter do not exist.

Decomposition:
- Package fifo_wr_arb_pkg:
  - State enum {IDLE, GRANT}.
  - Default NREQ/DSIZE constants.
  - Stall counter width constant (16).
- Sub-module rr_pick: purely combinational.
  - Inputs: NREQ request vector, last_id.
  - Outputs: any, pick index.
  - Used once in IDLE.

Test Plan:
- Reset, then req_valid=4'b0001 with a 3-beat packet 0xA1,0xA2,0xA3 (last on the 3rd), wfull=0 → gnt_id=0 one cycle after valid; winc high 3 consecutive cycles with wdata A1,A2,A3; busy falls after the 3rd beat.
- All four requesters valid with 1-beat packets, held continuously → grant order 0,1,2,3,0; exactly one idle cycle between writes.
- Requester 2 owns the port; wfull=1 for 5 cycles mid-packet → winc=0 and req_ready=0 throughout; data resumes with the next beat intact; requester 1 raising valid meanwhile is not granted until 2's last beat.
- Owner 1 drops valid for 3 cycles mid-packet while requester 3 is valid → gnt_id stays 1 and winc stays 0 for those cycles; requester 3 is granted only after 1's last beat.
- Assert wrst_n=0 asynchronously during GRANT on beat 2 of 4 → winc, req_ready, busy go 0 without waiting for a clock edge; after release, a request from 0 and 3 grants 0 first.
- With FIFO_WR_ARB_STALL_CNT_EN: 7 stalled cycles → stall_cnt=7; stall_clr together with a stall cycle → stall_cnt=0.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and default sizes for the round-robin, packet-locked FIFO write-port arbiter.
package fifo_wr_arb_pkg;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_DSIZE = 8;
   localparam int STALL_W   = 16;
endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first requesting index after last_id, wrapping around.
module rr_pick
   import fifo_wr_arb_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_id,
   output logic            any,
   output logic [IDW-1:0]  pick
);

   int idx;

   always_comb begin
      any  = |req;
      pick = '0;
      idx  = 0;
      // Walk offsets from farthest to nearest so the nearest request overwrites the pick.
      for (int off = NREQ; off >= 1; off--) begin
         idx = (int'(last_id) + off) % NREQ;
         if (req[idx]) pick = IDW'(idx);
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-locked round-robin arbiter sharing one async-FIFO write port between NREQ requesters.
// Define FIFO_WR_ARB_STALL_CNT_EN to add the saturating stall counter (stall_clr / stall_cnt).
module fifo_wr_arb
   import fifo_wr_arb_pkg::*;
#(
   parameter  int NREQ  = DEF_NREQ,
   parameter  int DSIZE = DEF_DSIZE,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*DSIZE-1:0] req_data,
   input  logic [NREQ-1:0]       req_last,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  wfull,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata,
   output logic [IDW-1:0]        gnt_id,
   output logic                  busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
   ,
   input  logic                  stall_clr,
   output logic [STALL_W-1:0]    stall_cnt
`endif
);

   state_t           state_reg, state_next;
   logic [IDW-1:0]   gnt_id_reg, gnt_id_next;
   logic [IDW-1:0]   last_id_reg, last_id_next;
   logic             any;
   logic [IDW-1:0]   pick;
   logic             owner_valid;
   logic             owner_last;
   logic             accept;
   logic [DSIZE-1:0] lane [NREQ];

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req     (req_valid),
      .last_id (last_id_reg),
      .any     (any),
      .pick    (pick)
   );

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane[gi]      = req_data[gi*DSIZE +: DSIZE];
      assign req_ready[gi] = busy & ~wfull & (gnt_id_reg == IDW'(gi));
   end

   assign owner_valid = req_valid[gnt_id_reg];
   assign owner_last  = req_last[gnt_id_reg];
   assign accept      = busy & owner_valid & ~wfull;
   assign wdata       = lane[gnt_id_reg];
   assign gnt_id      = gnt_id_reg;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_reg   <= IDLE;
         gnt_id_reg  <= '0;
         last_id_reg <= IDW'(NREQ - 1);
      end else begin
         state_reg   <= state_next;
         gnt_id_reg  <= gnt_id_next;
         last_id_reg <= last_id_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      gnt_id_next  = gnt_id_reg;
      last_id_next = last_id_reg;
      busy         = (state_reg == GRANT);
      winc         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (any) begin
               state_next   = GRANT;
               gnt_id_next  = pick;
               last_id_next = pick;
            end
         end
         GRANT: begin
            winc = accept;
            // The grant is released only on an accepted last beat, never on a valid drop.
            if (accept && owner_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
   logic [STALL_W-1:0] stall_cnt_reg;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         stall_cnt_reg <= '0;
      end else if (stall_clr) begin
         stall_cnt_reg <= '0;
      end else if (busy && owner_valid && wfull && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: vector table plus hand-written async-reset and stall-counter sequences.
module tb_fifo_wr_arb;

   logic        wclk = 1'b0;
   logic        wrst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_last = '0;
   logic [3:0]  req_ready;
   logic        wfull = 1'b0;
   logic        winc;
   logic [7:0]  wdata;
   logic [1:0]  gnt_id;
   logic        busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
   logic        stall_clr = 1'b0;
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int failures = 0;

   always #5 wclk = ~wclk;

   fifo_wr_arb dut (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .gnt_id    (gnt_id),
      .busy      (busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      ,
      .stall_clr (stall_clr),
      .stall_cnt (stall_cnt)
`endif
   );

   typedef struct {
      bit          rst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  last;
      logic        full;
      logic        e_winc;
      logic [7:0]  e_wdata;
      logic [3:0]  e_ready;
      logic [1:0]  e_gnt;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic add(input bit rst, input logic [3:0] valid, input logic [31:0] data,
                      input logic [3:0] last, input logic full, input logic e_winc,
                      input logic [7:0] e_wdata, input logic [3:0] e_ready,
                      input logic [1:0] e_gnt, input logic e_busy);
      vec_t v;
      v.rst = rst; v.valid = valid; v.data = data; v.last = last; v.full = full;
      v.e_winc = e_winc; v.e_wdata = e_wdata; v.e_ready = e_ready;
      v.e_gnt = e_gnt; v.e_busy = e_busy;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [3:0] valid, input logic [31:0] data,
                        input logic [3:0] last, input logic full);
      req_valid = valid;
      req_data  = data;
      req_last  = last;
      wfull     = full;
   endtask

   task automatic check_outs(input string name, input logic e_winc, input logic [7:0] e_wdata,
                             input logic [3:0] e_ready, input logic [1:0] e_gnt, input logic e_busy);
      check({name, "_ctl"}, {24'd0, winc, req_ready, gnt_id, busy},
            {24'd0, e_winc, e_ready, e_gnt, e_busy});
      if (e_winc) check({name, "_wdata"}, {24'd0, wdata}, {24'd0, e_wdata});
   endtask

   task automatic do_reset();
      @(posedge wclk);
      #2;
      wrst_n = 1'b0;
      drive(4'b0000, 32'h0, 4'b0000, 1'b0);
      #1;
      check_outs("reset", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
      @(negedge wclk);
      wrst_n = 1'b1;
   endtask

   initial begin
      // Single 3-beat packet from requester 0.
      add(1, 4'b0001, 32'h000000A1, 4'b0000, 0,  0, 8'h00, 4'b0000, 2'd0, 0);
      add(0, 4'b0001, 32'h000000A1, 4'b0000, 0,  1, 8'hA1, 4'b0001, 2'd0, 1);
      add(0, 4'b0001, 32'h000000A2, 4'b0000, 0,  1, 8'hA2, 4'b0001, 2'd0, 1);
      add(0, 4'b0001, 32'h000000A3, 4'b0001, 0,  1, 8'hA3, 4'b0001, 2'd0, 1);
      add(0, 4'b0000, 32'h00000000, 4'b0000, 0,  0, 8'h00, 4'b0000, 2'd0, 0);
      // All four single-beat requesters: order 0,1,2,3,0 with one idle cycle between.
      add(1, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0,  0, 8'h00, 4'b0000, 2'd0, 0);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0,  1, 8'hD0, 4'b0001, 2'd0, 1);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0,  0, 8'h00, 4'b0000, 2'd0, 0);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0,  1, 8'hD1, 4'b0010, 2'd1, 1);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0,  0, 8'h00, 4'b0000, 2'd1, 0);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0,  1, 8'hD2, 4'b0100, 2'd2, 1);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0,  0, 8'h00, 4'b0000, 2'd2, 0);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0,  1, 8'hD3, 4'b1000, 2'd3, 1);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0,  0, 8'h00, 4'b0000, 2'd3, 0);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0,  1, 8'hD0, 4'b0001, 2'd0, 1);
      // Requester 2 stalled by wfull for 5 cycles while requester 1 waits.
      add(1, 4'b0100, 32'h00B10000, 4'b0000, 0,  0, 8'h00, 4'b0000, 2'd0, 0);
      add(0, 4'b0100, 32'h00B10000, 4'b0000, 0,  1, 8'hB1, 4'b0100, 2'd2, 1);
      for (int i = 0; i < 5; i++)
         add(0, 4'b0110, 32'h00B2C100, 4'b0010, 1,  0, 8'h00, 4'b0000, 2'd2, 1);
      add(0, 4'b0110, 32'h00B2C100, 4'b0010, 0,  1, 8'hB2, 4'b0100, 2'd2, 1);
      add(0, 4'b0110, 32'h00B3C100, 4'b0110, 0,  1, 8'hB3, 4'b0100, 2'd2, 1);
      add(0, 4'b0010, 32'h0000C100, 4'b0010, 0,  0, 8'h00, 4'b0000, 2'd2, 0);
      add(0, 4'b0010, 32'h0000C100, 4'b0010, 0,  1, 8'hC1, 4'b0010, 2'd1, 1);
      // Owner 1 drops valid for 3 cycles while requester 3 waits.
      add(1, 4'b1010, 32'h33001100, 4'b1000, 0,  0, 8'h00, 4'b0000, 2'd0, 0);
      add(0, 4'b1010, 32'h33001100, 4'b1000, 0,  1, 8'h11, 4'b0010, 2'd1, 1);
      for (int i = 0; i < 3; i++)
         add(0, 4'b1000, 32'h33000000, 4'b1000, 0,  0, 8'h00, 4'b0010, 2'd1, 1);
      add(0, 4'b1010, 32'h33001200, 4'b1010, 0,  1, 8'h12, 4'b0010, 2'd1, 1);
      add(0, 4'b1000, 32'h33000000, 4'b1000, 0,  0, 8'h00, 4'b0000, 2'd1, 0);
      add(0, 4'b1000, 32'h33000000, 4'b1000, 0,  1, 8'h33, 4'b1000, 2'd3, 1);
      add(0, 4'b0000, 32'h00000000, 4'b0000, 0,  0, 8'h00, 4'b0000, 2'd3, 0);

      #1;
      check_outs("init_reset", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
      @(negedge wclk);
      wrst_n = 1'b1;

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         @(posedge wclk);
         #1;
         drive(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].full);
         @(negedge wclk);
         $display("vec %0d: valid=%b full=%b -> winc=%b wdata=%h ready=%b gnt=%0d busy=%b",
                  i, req_valid, wfull, winc, wdata, req_ready, gnt_id, busy);
         check_outs($sformatf("vec%0d", i), vecs[i].e_winc, vecs[i].e_wdata,
                    vecs[i].e_ready, vecs[i].e_gnt, vecs[i].e_busy);
      end

      // Asynchronous reset on beat 2 of a 4-beat packet, then 0 wins over 3.
      do_reset();
      @(posedge wclk); #1;
      drive(4'b0001, 32'h000000E1, 4'b0000, 1'b0);
      @(posedge wclk); #1;
      @(negedge wclk);
      check_outs("arst_beat1", 1'b1, 8'hE1, 4'b0001, 2'd0, 1'b1);
      @(posedge wclk); #1;
      drive(4'b0001, 32'h000000E2, 4'b0000, 1'b0);
      #1;
      check("arst_pre_winc", {31'd0, winc}, 32'd1);
      wrst_n = 1'b0;
      #1;
      check_outs("arst_mid", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
      $display("arst: winc=%b ready=%b busy=%b gnt=%0d", winc, req_ready, busy, gnt_id);
      drive(4'b1001, 32'hF30000F0, 4'b1001, 1'b0);
      @(negedge wclk);
      wrst_n = 1'b1;
      @(posedge wclk); #1;
      @(negedge wclk);
      check_outs("arst_after0", 1'b1, 8'hF0, 4'b0001, 2'd0, 1'b1);
      @(posedge wclk); #1;
      @(negedge wclk);
      check_outs("arst_gap", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
      @(posedge wclk); #1;
      @(negedge wclk);
      check_outs("arst_after3", 1'b1, 8'hF3, 4'b1000, 2'd3, 1'b1);

`ifdef FIFO_WR_ARB_STALL_CNT_EN
      do_reset();
      check("stall_rst", {16'd0, stall_cnt}, 32'd0);
      @(posedge wclk); #1;
      drive(4'b0001, 32'h00000055, 4'b0000, 1'b0);
      @(posedge wclk); #1;
      drive(4'b0001, 32'h00000055, 4'b0000, 1'b1);
      repeat (7) @(posedge wclk);
      #1;
      drive(4'b0001, 32'h00000055, 4'b0000, 1'b0);
      @(negedge wclk);
      check("stall_7", {16'd0, stall_cnt}, 32'd7);
      $display("stall: cnt=%0d", stall_cnt);
      @(posedge wclk); #1;
      drive(4'b0001, 32'h00000055, 4'b0000, 1'b1);
      stall_clr = 1'b1;
      @(posedge wclk); #1;
      stall_clr = 1'b0;
      @(negedge wclk);
      check("stall_clr", {16'd0, stall_cnt}, 32'd0);
      @(posedge wclk); #1;
      @(negedge wclk);
      check("stall_after_clr", {16'd0, stall_cnt}, 32'd1);
      $display("stall: cnt after clear=%0d", stall_cnt);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
